// File: rtl/lc3b_mc_alu.sv
// rtl/lc3b_mc_alu.sv - multi-cycle LC-3b ALU with start/done handshake
// Optional feature macro: LC3B_ALU_MULDIV_EN (iterative mul/divu/remu).
// Without it, opcodes 7-9 behave as reserved and dz is tied low.
module lc3b_mc_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_PASS = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
`ifdef LC3B_ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_DIVU = 4'd8;
  localparam logic [3:0] OP_REMU = 4'd9;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] f_n;
  logic [WIDTH-1:0] simple_res;
  logic [SHW-1:0]   sh;

  assign sh   = b[SHW-1:0];
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Single-cycle results, computed straight from the live operands at acceptance
  always_comb begin
    simple_res = '0;
    case (aluop)
      OP_ADD:  simple_res = a + b;
      OP_AND:  simple_res = a & b;
      OP_NOT:  simple_res = ~a;
      OP_PASS: simple_res = a;
      OP_SLL:  simple_res = a << sh;
      OP_SRL:  simple_res = a >> sh;
      OP_SRA:  simple_res = $unsigned($signed(a) >>> sh);
      default: simple_res = '0;
    endcase
  end

`ifdef LC3B_ALU_MULDIV_EN
  // acc: product accumulator / partial remainder
  // opa: shifting multiplicand / dividend being shifted into quotient
  // opb: shifting multiplier / constant divisor
  logic [WIDTH-1:0] acc, acc_n, opa, opa_n, opb, opb_n;
  logic [SHW-1:0]   cnt, cnt_n;
  logic [3:0]       op_r, op_n;
  logic             dz_r, dz_n;
  logic             is_md;
  logic [WIDTH-1:0] mul_acc, div_rem, div_q;
  logic [WIDTH:0]   rem_sh, rem_diff;

  assign is_md = (aluop == OP_MUL) || (aluop == OP_DIVU) || (aluop == OP_REMU);
  assign dz    = dz_r;

  // One shift-add step and one restoring-division step; the FSM picks which to keep
  always_comb begin
    mul_acc  = opb[0] ? (acc + opa) : acc;
    rem_sh   = {acc, opa[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
    if (!rem_diff[WIDTH]) begin
      div_rem = rem_diff[WIDTH-1:0];
      div_q   = {opa[WIDTH-2:0], 1'b1};
    end else begin
      div_rem = rem_sh[WIDTH-1:0];
      div_q   = {opa[WIDTH-2:0], 1'b0};
    end
  end
`else
  assign dz = 1'b0;
`endif

  // Next-state, operand capture and result selection
  always_comb begin
    state_n = state;
    f_n     = f;
`ifdef LC3B_ALU_MULDIV_EN
    dz_n  = dz_r;
    acc_n = acc;
    opa_n = opa;
    opb_n = opb;
    cnt_n = cnt;
    op_n  = op_r;
`endif
    case (state)
      IDLE: begin
        if (start) begin
`ifdef LC3B_ALU_MULDIV_EN
          if (is_md && (b != '0)) begin
            state_n = CALC;
            acc_n   = '0;
            opa_n   = a;
            opb_n   = b;
            cnt_n   = '0;
            op_n    = aluop;
          end else begin
            state_n = DONE;
            if (aluop == OP_DIVU) begin
              f_n  = '1;
              dz_n = 1'b1;
            end else if (aluop == OP_REMU) begin
              f_n  = a;
              dz_n = 1'b1;
            end else begin
              f_n  = simple_res;
              dz_n = 1'b0;
            end
          end
`else
          state_n = DONE;
          f_n     = simple_res;
`endif
        end
      end
`ifdef LC3B_ALU_MULDIV_EN
      CALC: begin
        cnt_n = cnt + 1'b1;
        if (op_r == OP_MUL) begin
          acc_n = mul_acc;
          opa_n = opa << 1;
          opb_n = opb >> 1;
        end else begin
          acc_n = div_rem;
          opa_n = div_q;
        end
        if (cnt == SHW'(WIDTH - 1)) begin
          state_n = DONE;
          dz_n    = 1'b0;
          if (op_r == OP_MUL)       f_n = mul_acc;
          else if (op_r == OP_DIVU) f_n = div_q;
          else                      f_n = div_rem;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Result and iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f    <= '0;
`ifdef LC3B_ALU_MULDIV_EN
      dz_r <= 1'b0;
      acc  <= '0;
      opa  <= '0;
      opb  <= '0;
      cnt  <= '0;
      op_r <= '0;
`endif
    end else begin
      f    <= f_n;
`ifdef LC3B_ALU_MULDIV_EN
      dz_r <= dz_n;
      acc  <= acc_n;
      opa  <= opa_n;
      opb  <= opb_n;
      cnt  <= cnt_n;
      op_r <= op_n;
`endif
    end
  end

endmodule

// File: tb/tb_lc3b_mc_alu.sv
// tb/tb_lc3b_mc_alu.sv - randomized and directed checks of lc3b_mc_alu against a behavioural model
module tb_lc3b_mc_alu;
  localparam int W = 16;
`ifdef LC3B_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   aluop = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, dz;
  logic [W-1:0] f;

  lc3b_mc_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .aluop(aluop), .a(a), .b(b),
    .busy(busy), .done(done), .f(f), .dz(dz)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycle number, acceptance cycle and expected done cycle of the op in flight
  int           cyc = 0;
  int           acc_c = -10;
  int           done_c = -10;
  logic [W-1:0] pend_f = '0, last_f = '0;
  logic         pend_dz = 1'b0, last_dz = 1'b0;

  function automatic logic [W-1:0] model_f(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned xu = x;
    longint unsigned yu = y;
    longint unsigned mask = (64'd1 << W) - 1;
    int unsigned sh = y % W;
    case (op)
      4'd0: return W'((xu + yu) & mask);
      4'd1: return x & y;
      4'd2: return ~x;
      4'd3: return x;
      4'd4: return W'((xu << sh) & mask);
      4'd5: return W'(xu >> sh);
      4'd6: return W'((xu >> sh) | (x[W-1] ? (mask & ~(mask >> sh)) : 64'd0));
      4'd7: return MD ? W'((xu * yu) & mask) : '0;
      4'd8: return !MD ? '0 : (yu == 0) ? W'(mask) : W'(xu / yu);
      4'd9: return !MD ? '0 : (yu == 0) ? x : W'(xu % yu);
      default: return '0;
    endcase
  endfunction

  function automatic logic model_dz(input logic [3:0] op, input logic [W-1:0] y);
    return MD && (op == 4'd8 || op == 4'd9) && (y == '0);
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] y);
    return (MD && op >= 4'd7 && op <= 4'd9 && y != '0) ? W + 1 : 1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model update at each clock edge: accept a request only when not busy
  always @(posedge clk) begin
    if (!rst && start && !(acc_c < cyc && cyc <= done_c)) begin
      acc_c   = cyc;
      done_c  = cyc + model_lat(aluop, b);
      pend_f  = model_f(aluop, a, b);
      pend_dz = model_dz(aluop, b);
    end
    cyc = cyc + 1;
  end

  // Reset drops any op in flight and clears the visible result
  always @(posedge rst) begin
    acc_c   = -10;
    done_c  = -10;
    last_f  = '0;
    last_dz = 1'b0;
  end

  // Per-cycle comparison, sampled just after the active edge
  always begin
    @(posedge clk);
    #1;
    if (cyc == done_c) begin
      last_f  = pend_f;
      last_dz = pend_dz;
    end
    chk("busy", W'(busy), W'(acc_c < cyc && cyc <= done_c));
    chk("done", W'(done), W'(cyc == done_c));
    chk("f", f, last_f);
    if (rst || cyc == done_c) chk("dz", W'(dz), W'(last_dz));
  end

  // Directed op with hand-computed expectations; noise scrambles inputs while busy
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ef, input logic edz, input int elat, input bit noise);
    int k;
    @(negedge clk);
    start = 1'b1; aluop = op; a = x; b = y;
    @(posedge clk);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) break;
      if (noise) begin
        start = $urandom_range(0, 1) == 1;
        aluop = 4'($urandom_range(0, 15));
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", W'(k), W'(elat));
    chk("lit_f", f, ef);
    chk("lit_dz", W'(dz), W'(edz));
    @(posedge clk);
    #1;
    chk("busy_after_done", W'(busy), '0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_f", f, '0);
    chk("reset_busy", W'(busy), '0);
    rst = 1'b0;

    run_op(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1, 1'b0);
    run_op(4'd6, 16'h8000, 16'h000F, 16'hFFFF, 1'b0, 1, 1'b0);
    run_op(4'd5, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1, 1'b0);
    run_op(4'd4, 16'h00F0, 16'h0003, 16'h0780, 1'b0, 1, 1'b0);
    run_op(4'd6, 16'h8001, 16'h0010, 16'h8001, 1'b0, 1, 1'b0);
    run_op(4'd2, 16'h0F0F, 16'h0000, 16'hF0F0, 1'b0, 1, 1'b0);
    run_op(4'd12, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1, 1'b0);
    run_op(4'd7, 16'h0123, 16'h0010, MD ? 16'h1230 : 16'h0000, 1'b0, MD ? 17 : 1, 1'b1);
    run_op(4'd8, 16'd100, 16'd7, MD ? 16'd14 : 16'd0, 1'b0, MD ? 17 : 1, 1'b0);
    run_op(4'd9, 16'd100, 16'd7, MD ? 16'd2 : 16'd0, 1'b0, MD ? 17 : 1, 1'b0);
    run_op(4'd8, 16'h1234, 16'h0000, MD ? 16'hFFFF : 16'h0000, MD, 1, 1'b0);
    run_op(4'd9, 16'h1234, 16'h0000, MD ? 16'h1234 : 16'h0000, MD, 1, 1'b0);

    // Reset in cycle 5 of a multiply; f still holds the previous non-zero result
    @(negedge clk);
    start = 1'b1; aluop = 4'd7; a = 16'h00FF; b = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_f", f, '0);
    chk("rst_dz", W'(dz), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    run_op(4'd0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1, 1'b0);

    // Randomized traffic, including starts while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 599) == 0);
      start = ($urandom_range(0, 2) == 0);
      aluop = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      a     = W'($urandom);
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        default: b = W'($urandom);
      endcase
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
